signal_encoder: RTL and testbench

//  Transmit end of the 3-bit level-signalling link; signal_decoder in the ADC path is the receiver.

---
 rtl/signal_encoder_pkg.sv | 15 +
 rtl/signal_encoder_dac_level_map.sv | 20 ++
 rtl/signal_encoder.sv | 198 +++++++++++++++++++
 tb/tb_signal_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_encoder_pkg.sv
// Shared constants and types for the 3-bit level-signalling link.
// The receiver (signal_decoder) relies on the same preamble symbols and idle word.
package signal_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } enc_state_e;

    localparam logic [2:0]  PREAMBLE_A = 3'b011;
    localparam logic [2:0]  PREAMBLE_B = 3'b100;
    localparam logic [31:0] IDLE_WORD  = 32'h0000_0000;

endpackage

// File: rtl/signal_encoder_dac_level_map.sv
// Maps a 3-bit symbol onto the centre of its DAC level bin, sign-extended to 16 bits.
// The symbol lands in bits [DAC_WIDTH-BIT_OFFSET-1 -: 3] with a 1 just below it.
module dac_level_map #(
    parameter int DAC_WIDTH  = 14,
    parameter int BIT_OFFSET = 0
) (
    input  logic [2:0]  sym_i,
    output logic [15:0] sample_o
);

    localparam int SHIFT = 16 - DAC_WIDTH + BIT_OFFSET;

    // Build the level at the top of a 16-bit word, then an arithmetic shift
    // moves it into place and sign-extends the upper bits in one step.
    logic signed [15:0] centred;

    assign centred  = {sym_i, 1'b1, 12'b0};
    assign sample_o = centred >>> SHIFT;

endmodule

// File: rtl/signal_encoder.sv
// Transmit end of the level-signalling link: symbols in on S_AXIS, framed DAC samples out on M_AXIS.
// Each frame is PREAMBLE_SYMS alternating preamble symbols, then the payload, SYMBOL_LEN samples per symbol.
module signal_encoder
    import signal_encoder_pkg::*;
#(
    parameter int DAC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BIT_OFFSET       = 0,
    parameter int SYMBOL_LEN       = 16,
    parameter int PREAMBLE_SYMS    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic                        S_AXIS_tlast,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        underrun,
    output logic [1:0]                  state_o
);

    localparam int CNT_W  = $clog2(SYMBOL_LEN);
    localparam int PSYM_W = $clog2(PREAMBLE_SYMS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SYMBOL_LEN - 1);
    localparam logic [PSYM_W-1:0] PSYM_LAST = PSYM_W'(PREAMBLE_SYMS - 1);

    // Both ports use plain AXI-Stream semantics: a transfer happens on a rising
    // edge where valid and ready are both high; a valid word is held until taken.
    enc_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [PSYM_W-1:0]           psym_q, psym_d;
    logic [2:0]                  cur_sym_q, cur_sym_d;
    logic                        cur_last_q, cur_last_d;
    logic                        gap_q, gap_d;
    logic                        skid_valid_q, skid_valid_d;
    logic [2:0]                  skid_sym_q, skid_sym_d;
    logic                        skid_last_q, skid_last_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q;
    logic                        tready_q;
    logic                        busy_q;
    logic                        frame_done_q, frame_done_d;
    logic                        underrun_q, underrun_d;

    logic        m_hs, s_hs, slot_end, skid_load, next_idle;
    logic [2:0]  map_sym;
    logic [15:0] level;
    logic        unused_tdata_bits;

    assign unused_tdata_bits = ^S_AXIS_tdata[7:3];

    assign m_hs     = tvalid_q && M_AXIS_tready;
    assign s_hs     = S_AXIS_tvalid && tready_q;
    assign slot_end = (cnt_q == CNT_LAST);

    dac_level_map #(
        .DAC_WIDTH  (DAC_WIDTH),
        .BIT_OFFSET (BIT_OFFSET)
    ) u_level_map (
        .sym_i    (map_sym),
        .sample_o (level)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        psym_d       = psym_q;
        cur_sym_d    = cur_sym_q;
        cur_last_d   = cur_last_q;
        gap_d        = gap_q;
        skid_valid_d = skid_valid_q;
        skid_sym_d   = skid_sym_q;
        skid_last_d  = skid_last_q;
        tdata_d      = tdata_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        skid_load    = 1'b0;
        map_sym      = PREAMBLE_A;
        next_idle    = 1'b1;

        if (m_hs) begin
            cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (skid_valid_q) begin
                        state_d = ST_SYNC;
                        psym_d  = '0;
                        gap_d   = 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (slot_end) begin
                        if (psym_q == PSYM_LAST) begin
                            state_d   = ST_DATA;
                            skid_load = 1'b1;
                        end else begin
                            psym_d = psym_q + PSYM_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (slot_end) begin
                        if (cur_last_q && !gap_q) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else if (skid_valid_q) begin
                            skid_load = 1'b1;
                            gap_d     = 1'b0;
                        end else begin
                            // Source fell behind: fill this slot with the idle level.
                            underrun_d = 1'b1;
                            gap_d      = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (skid_load) begin
                cur_sym_d    = skid_sym_q;
                cur_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end

            unique case (state_d)
                ST_SYNC: begin
                    next_idle = 1'b0;
                    map_sym   = psym_d[0] ? PREAMBLE_B : PREAMBLE_A;
                end
                ST_DATA: begin
                    next_idle = gap_d;
                    map_sym   = cur_sym_d;
                end
                default: next_idle = 1'b1;
            endcase

            tdata_d = next_idle ? AXIS_TDATA_WIDTH'(IDLE_WORD)
                                : AXIS_TDATA_WIDTH'({level, level});
        end

        if (s_hs) begin
            skid_valid_d = 1'b1;
            skid_sym_d   = S_AXIS_tdata[2:0];
            skid_last_d  = S_AXIS_tlast;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            psym_q       <= '0;
            cur_sym_q    <= '0;
            cur_last_q   <= 1'b0;
            gap_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_sym_q   <= '0;
            skid_last_q  <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            psym_q       <= psym_d;
            cur_sym_q    <= cur_sym_d;
            cur_last_q   <= cur_last_d;
            gap_q        <= gap_d;
            skid_valid_q <= skid_valid_d;
            skid_sym_q   <= skid_sym_d;
            skid_last_q  <= skid_last_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= 1'b1;
            tready_q     <= !skid_valid_d;
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign S_AXIS_tready = tready_q;
    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_signal_encoder.sv
// Bench for signal_encoder: one instance at BIT_OFFSET=0 and one at BIT_OFFSET=4 share all inputs.
// Expected words are queued as frames are built and popped against the words the DUT hands over.
module tb_signal_encoder;

    localparam int SL = 16;
    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready, s_tready4;
    logic [31:0] m_tdata, m_tdata4;
    logic        m_tvalid, m_tvalid4;
    logic        m_tready;
    logic        busy, busy4, frame_done, frame_done4, underrun, underrun4;
    logic [1:0]  st, st4;

    always #4 clk = ~clk;

    signal_encoder #(.BIT_OFFSET(0)) u_dut (
        .clk(clk), .rst(rst),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tlast(s_tlast),
        .S_AXIS_tready(s_tready),
        .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
        .busy(busy), .frame_done(frame_done), .underrun(underrun), .state_o(st)
    );

    signal_encoder #(.BIT_OFFSET(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tlast(s_tlast),
        .S_AXIS_tready(s_tready4),
        .M_AXIS_tdata(m_tdata4), .M_AXIS_tvalid(m_tvalid4), .M_AXIS_tready(m_tready),
        .busy(busy4), .frame_done(frame_done4), .underrun(underrun4), .state_o(st4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0]  src_sym[$];
    logic        src_last[$];
    logic [31:0] exp_q[$];
    logic [2:0]  exp_sym_q[$];
    logic [31:0] hs_word[$];
    logic [31:0] hs_word4[$];
    logic        hs_busy[$];
    int fd_count, fd_at, ur_count, hold_errs;

    // Independent model of the level map: bit placement written out directly.
    function automatic logic [15:0] lvl(input logic [2:0] v, input int off);
        logic [15:0] r;
        int top;
        r   = '0;
        top = 13 - off;
        r[top -: 3] = v;
        r[top - 3]  = 1'b1;
        for (int i = top + 1; i < 16; i++) r[i] = v[2];
        return r;
    endfunction

    task automatic clear_sb();
        src_sym.delete(); src_last.delete();
        exp_q.delete(); exp_sym_q.delete();
    endtask

    task automatic add_preamble();
        for (int p = 0; p < PS; p++) begin
            for (int k = 0; k < SL; k++) begin
                exp_q.push_back({lvl((p % 2) ? 3'b100 : 3'b011, 0), lvl((p % 2) ? 3'b100 : 3'b011, 0)});
                exp_sym_q.push_back((p % 2) ? 3'b100 : 3'b011);
            end
        end
    endtask

    task automatic add_sym(input logic [2:0] v, input logic last);
        src_sym.push_back(v);
        src_last.push_back(last);
        for (int k = 0; k < SL; k++) begin
            exp_q.push_back({lvl(v, 0), lvl(v, 0)});
            exp_sym_q.push_back(v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives source and sink once per cycle and records every M_AXIS transfer.
    task automatic run_traffic(input int ready_pct, input int stall_idx, input int stall_len,
                               input int fd_target, input int max_cyc);
        int idx = 0, stall_cnt = 0, post = 0, nwords = 0, cyc = 0;
        logic s_hs = 1'b0, prev_stall = 1'b0;
        logic [31:0] prev_word = '0;
        hs_word.delete(); hs_word4.delete(); hs_busy.delete();
        fd_count = 0; fd_at = -1; ur_count = 0; hold_errs = 0;
        while (cyc < max_cyc && post < 4) begin
            @(negedge clk);
            cyc++;
            if (s_hs) idx++;
            if (m_tvalid && prev_stall && m_tdata !== prev_word) hold_errs++;
            if (frame_done) begin
                fd_count++;
                if (fd_count == 1) fd_at = nwords;
            end
            if (underrun) ur_count++;
            if (fd_count >= fd_target) post++;
            if (idx < src_sym.size() && !(idx == stall_idx && stall_cnt < stall_len)) begin
                s_tvalid = 1'b1;
                s_tdata  = {5'(idx * 7 + 3), src_sym[idx]};
                s_tlast  = src_last[idx];
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                if (idx == stall_idx && stall_cnt < stall_len) stall_cnt++;
            end
            m_tready = ($urandom_range(99) < ready_pct);
            s_hs = s_tvalid && s_tready;
            if (m_tvalid && m_tready) begin
                hs_word.push_back(m_tdata);
                hs_word4.push_back(m_tdata4);
                hs_busy.push_back(busy);
                if (busy) nwords++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_word  = m_tdata;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%b want=0", m_tvalid); else n_pass++;
        n_checks++; if (m_tdata !== 32'h0) $display("FAIL rst_tdata got=%h want=0", m_tdata); else n_pass++;
        n_checks++; if (s_tready !== 1'b0) $display("FAIL rst_s_tready got=%b want=0", s_tready); else n_pass++;
        n_checks++; if ({busy, frame_done, underrun} !== 3'b000)
            $display("FAIL rst_flags got=%b want=000", {busy, frame_done, underrun}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (m_tvalid !== 1'b1) $display("FAIL first_tvalid got=%b want=1", m_tvalid); else n_pass++;
        n_checks++; if (m_tdata !== 32'h0) $display("FAIL first_tdata got=%h want=0", m_tdata); else n_pass++;
        n_checks++; if (s_tready !== 1'b1) $display("FAIL first_s_tready got=%b want=1", s_tready); else n_pass++;
        n_checks++; if (st !== 2'd0) $display("FAIL first_state got=%0d want=0", st); else n_pass++;
        repeat (30) begin
            @(negedge clk);
            if (m_tvalid !== 1'b1 || m_tdata !== 32'h0 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL idle_stream bad_cycles=%0d want=0", bad); else n_pass++;
    endtask

    task automatic test_frame();
        logic [31:0] e;
        logic [2:0] es;
        int gaps = 0;
        logic seen = 1'b0;
        do_reset();
        clear_sb();
        add_preamble();
        add_sym(3'd3, 1'b0); add_sym(3'd0, 1'b0); add_sym(3'd4, 1'b1);
        run_traffic(100, -1, 0, 1, 400);
        foreach (hs_word[i]) begin
            if (hs_busy[i]) begin
                if (seen && !hs_busy[i - 1]) gaps++;
                seen = 1'b1;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL frame_extra word=%h want none", hs_word[i]);
                end else begin
                    e = exp_q.pop_front();
                    es = exp_sym_q.pop_front();
                    if (hs_word[i] !== e) $display("FAIL frame_word idx=%0d got=%h want=%h", i, hs_word[i], e);
                    else n_pass++;
                    n_checks++;
                    if (hs_word4[i] !== {lvl(es, 4), lvl(es, 4)})
                        $display("FAIL off4_word idx=%0d got=%h want=%h", i, hs_word4[i], {lvl(es, 4), lvl(es, 4)});
                    else n_pass++;
                    n_checks++;
                    if (hs_word4[i][9:7] !== es || hs_word4[i][25:23] !== es)
                        $display("FAIL off4_decode idx=%0d got=%0d want=%0d", i, hs_word4[i][9:7], es);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (exp_q.size() !== 0) $display("FAIL frame_missing left=%0d want=0", exp_q.size()); else n_pass++;
        n_checks++; if (fd_count !== 1) $display("FAIL frame_done_count got=%0d want=1", fd_count); else n_pass++;
        n_checks++; if (fd_at !== 112) $display("FAIL frame_done_at got=%0d want=112", fd_at); else n_pass++;
        n_checks++; if (ur_count !== 0) $display("FAIL frame_underrun got=%0d want=0", ur_count); else n_pass++;
        n_checks++; if (gaps !== 0) $display("FAIL frame_bubbles got=%0d want=0", gaps); else n_pass++;
    endtask

    task automatic test_random_ready();
        logic [31:0] e;
        int bad = 0;
        do_reset();
        clear_sb();
        add_preamble();
        add_sym(3'd3, 1'b0); add_sym(3'd0, 1'b0); add_sym(3'd4, 1'b1);
        run_traffic(50, -1, 0, 1, 1500);
        foreach (hs_word[i]) begin
            if (hs_busy[i]) begin
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if (hs_word[i] !== e) bad++;
                end
            end
        end
        n_checks++; if (bad !== 0) $display("FAIL rand_words bad=%0d want=0", bad); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL rand_missing left=%0d want=0", exp_q.size()); else n_pass++;
        n_checks++; if (hold_errs !== 0) $display("FAIL rand_hold changes=%0d want=0", hold_errs); else n_pass++;
        n_checks++; if (fd_at !== 112) $display("FAIL rand_done_at got=%0d want=112", fd_at); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [31:0] e;
        int bad = 0, gap_words = 0;
        do_reset();
        clear_sb();
        add_preamble();
        add_sym(3'd3, 1'b0); add_sym(3'd0, 1'b0); add_sym(3'd4, 1'b0);
        add_sym(3'd1, 1'b0); add_sym(3'd6, 1'b1);
        run_traffic(100, 2, 40, 1, 600);
        foreach (hs_word[i]) begin
            if (hs_busy[i]) begin
                if (hs_word[i] === 32'h0) gap_words++;
                else if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if (hs_word[i] !== e) bad++;
                end
            end
        end
        n_checks++; if (bad !== 0) $display("FAIL ur_words bad=%0d want=0", bad); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL ur_missing left=%0d want=0", exp_q.size()); else n_pass++;
        n_checks++; if (ur_count < 1) $display("FAIL ur_pulses got=%0d want>=1", ur_count); else n_pass++;
        n_checks++; if (gap_words !== ur_count * SL)
            $display("FAIL ur_gap_words got=%0d want=%0d", gap_words, ur_count * SL); else n_pass++;
        n_checks++; if (fd_count !== 1) $display("FAIL ur_frame_done got=%0d want=1", fd_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int bad = 0, first_b = -1, last_b = -1, idle_between = 0;
        do_reset();
        clear_sb();
        add_preamble();
        add_sym(3'd5, 1'b0); add_sym(3'd2, 1'b1);
        add_preamble();
        add_sym(3'd7, 1'b1);
        run_traffic(100, -1, 0, 2, 600);
        foreach (hs_word[i]) begin
            if (hs_busy[i]) begin
                if (first_b < 0) first_b = i;
                last_b = i;
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if (hs_word[i] !== e) bad++;
                end
            end
        end
        for (int i = first_b + 1; i < last_b; i++) if (!hs_busy[i]) idle_between++;
        n_checks++; if (bad !== 0) $display("FAIL b2b_words bad=%0d want=0", bad); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_missing left=%0d want=0", exp_q.size()); else n_pass++;
        n_checks++; if (idle_between !== 1) $display("FAIL b2b_idle got=%0d want=1", idle_between); else n_pass++;
        n_checks++; if (fd_count !== 2) $display("FAIL b2b_frame_done got=%0d want=2", fd_count); else n_pass++;
        n_checks++; if (fd_at !== 96) $display("FAIL b2b_first_done_at got=%0d want=96", fd_at); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] e;
        int bad = 0;
        do_reset();
        clear_sb();
        add_preamble();
        add_sym(3'd3, 1'b0); add_sym(3'd0, 1'b0); add_sym(3'd4, 1'b1);
        run_traffic(100, -1, 0, 1, 80);
        n_checks++; if (st !== 2'd2) $display("FAIL mid_state got=%0d want=2", st); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({m_tvalid, s_tready, busy} !== 3'b000)
            $display("FAIL mid_rst_ctrl got=%b want=000", {m_tvalid, s_tready, busy}); else n_pass++;
        n_checks++; if (m_tdata !== 32'h0) $display("FAIL mid_rst_tdata got=%h want=0", m_tdata); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_sb();
        add_preamble();
        add_sym(3'd6, 1'b0); add_sym(3'd1, 1'b1);
        run_traffic(100, -1, 0, 1, 400);
        n_checks++;
        if (hs_word.size() == 0) $display("FAIL mid_first_word got=none want=00000000");
        else if (hs_word[0] !== 32'h0 || hs_busy[0] !== 1'b0)
            $display("FAIL mid_first_word got=%h busy=%b want=00000000 busy=0", hs_word[0], hs_busy[0]);
        else n_pass++;
        foreach (hs_word[i]) begin
            if (hs_busy[i]) begin
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if (hs_word[i] !== e) bad++;
                end
            end
        end
        n_checks++; if (bad !== 0) $display("FAIL mid_refresh_words bad=%0d want=0", bad); else n_pass++;
        n_checks++; if (fd_at !== 96) $display("FAIL mid_refresh_done_at got=%0d want=96", fd_at); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_random_ready();
        test_underrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
